// File: rtl/planificador_solicitudes_pkg.sv
// Shared constants for the elevator request scheduler: direction states,
// request kinds and motion actions.
package elevador_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_SUBE = 2'd1,
    DIR_BAJA = 2'd2
  } dir_t;

  localparam logic [1:0] REQ_CAB = 2'd0;
  localparam logic [1:0] REQ_UP  = 2'd1;
  localparam logic [1:0] REQ_DN  = 2'd2;

  localparam logic [1:0] ACC_PARADO = 2'd0;
  localparam logic [1:0] ACC_SUBE   = 2'd1;
  localparam logic [1:0] ACC_BAJA   = 2'd2;

endpackage

// File: rtl/planificador_solicitudes_if.sv
// Request bus into the scheduler: one call per cycle (kind + floor).
interface planificador_solicitudes_if #(
  parameter int N_PISOS = 4
) ();
  localparam int W_PISO = $clog2(N_PISOS);

  logic              req_valid;
  logic [1:0]        req_tipo;
  logic [W_PISO-1:0] req_piso;

  modport master (output req_valid, req_tipo, req_piso);
  modport slave  (input  req_valid, req_tipo, req_piso);
endinterface

// File: rtl/planificador_solicitudes_buscador.sv
// Priority floor search: lowest or highest set bit of vec strictly above or
// strictly below floor p (p carries one extra bit so the top floor never wraps).
module buscador_piso #(
  parameter int N_PISOS = 4,
  localparam int W_PISO = $clog2(N_PISOS)
) (
  input  logic [N_PISOS-1:0] vec,
  input  logic [W_PISO:0]    p,
  input  logic               above,
  input  logic               lowest,
  output logic               found,
  output logic [W_PISO-1:0]  idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned f = 0; f < N_PISOS; f++) begin
      if (vec[f] &&
          (above ? ((W_PISO+1)'(f) > p) : ((W_PISO+1)'(f) < p)) &&
          (!found || !lowest)) begin
        found = 1'b1;
        idx   = W_PISO'(f);
      end
    end
  end

endmodule

// File: rtl/planificador_solicitudes.sv
// Elevator request store plus collective-SCAN direction FSM; drives the motion
// FSM with a registered target floor and the current sweep direction.
module planificador_solicitudes
  import elevador_pkg::*;
#(
  parameter int N_PISOS = 4,
  localparam int W_PISO = $clog2(N_PISOS)
) (
  input  logic                      clk,
  input  logic                      rst,
  planificador_solicitudes_if.slave req,
  input  logic                      borrar,
  input  logic [W_PISO-1:0]         piso_actual,
  input  logic [1:0]                accion,
  input  logic                      puertas,
  output logic [W_PISO-1:0]         objetivo,
  output logic                      objetivo_valid,
  output logic [1:0]                direccion,
  output logic [N_PISOS-1:0]        pend_cab,
  output logic [N_PISOS-1:0]        pend_up,
  output logic [N_PISOS-1:0]        pend_dn,
  output logic                      err_req
);

  localparam int WP = W_PISO + 1;

  dir_t state, state_n;

  logic [N_PISOS-1:0] cab, up, dn, pend;
  logic [N_PISOS-1:0] sel_p, sel_req;
  logic [N_PISOS-1:0] ins_cab, ins_up, ins_dn;
  logic [N_PISOS-1:0] clr_cab, clr_up, clr_dn;
  logic [N_PISOS-1:0] vec_a, vec_c;
  logic [WP-1:0]      p_ext, rp_ext, dist_a, dist_c;
  logic               p_ok, req_ilegal, req_ok;
  logic               a_found, b_found, c_found, d_found;
  logic [W_PISO-1:0]  a_idx, b_idx, c_idx, d_idx;
  logic               arriba, abajo, sube_cerca;
  logic               tgt_found;
  logic [W_PISO-1:0]  tgt;

  assign pend   = cab | up | dn;
  assign p_ext  = {1'b0, piso_actual};
  assign rp_ext = {1'b0, req.req_piso};
  assign p_ok   = p_ext < WP'(N_PISOS);

  always_comb begin
    sel_p   = '0;
    sel_req = '0;
    for (int unsigned f = 0; f < N_PISOS; f++) begin
      if (p_ext == WP'(f))  sel_p[f]   = 1'b1;
      if (rp_ext == WP'(f)) sel_req[f] = 1'b1;
    end
  end

  assign req_ilegal = (req.req_tipo == 2'd3) ||
                      (rp_ext >= WP'(N_PISOS)) ||
                      (req.req_tipo == REQ_UP && rp_ext == WP'(N_PISOS - 1)) ||
                      (req.req_tipo == REQ_DN && rp_ext == '0);
  assign req_ok  = req.req_valid && !req_ilegal;
  assign ins_cab = (req_ok && req.req_tipo == REQ_CAB) ? sel_req : '0;
  assign ins_up  = (req_ok && req.req_tipo == REQ_UP)  ? sel_req : '0;
  assign ins_dn  = (req_ok && req.req_tipo == REQ_DN)  ? sel_req : '0;

  // In IDLE the A/C searches look at every pending call (nearest-floor rule);
  // while sweeping they only see calls that can be served on the way.
  assign vec_a = (state == DIR_IDLE) ? pend : (cab | up);
  assign vec_c = (state == DIR_IDLE) ? pend : (cab | dn);

  buscador_piso #(.N_PISOS(N_PISOS)) u_busca_a (
    .vec(vec_a), .p(p_ext), .above(1'b1), .lowest(1'b1), .found(a_found), .idx(a_idx));
  buscador_piso #(.N_PISOS(N_PISOS)) u_busca_b (
    .vec(dn),    .p(p_ext), .above(1'b1), .lowest(1'b0), .found(b_found), .idx(b_idx));
  buscador_piso #(.N_PISOS(N_PISOS)) u_busca_c (
    .vec(vec_c), .p(p_ext), .above(1'b0), .lowest(1'b0), .found(c_found), .idx(c_idx));
  buscador_piso #(.N_PISOS(N_PISOS)) u_busca_d (
    .vec(up),    .p(p_ext), .above(1'b0), .lowest(1'b1), .found(d_found), .idx(d_idx));

  assign arriba     = a_found | b_found;
  assign abajo      = c_found | d_found;
  assign dist_a     = {1'b0, a_idx} - p_ext;
  assign dist_c     = p_ext - {1'b0, c_idx};
  assign sube_cerca = dist_a <= dist_c;

  // Turnaround: the last floor of a sweep also clears the opposite-direction call.
  assign clr_cab = puertas ? sel_p : '0;
  assign clr_up  = (puertas && (state != DIR_BAJA || !abajo))  ? sel_p : '0;
  assign clr_dn  = (puertas && (state != DIR_SUBE || !arriba)) ? sel_p : '0;

  always_comb begin
    state_n = state;
    if (borrar) begin
      state_n = DIR_IDLE;
    end else if (p_ok && accion == ACC_PARADO) begin
      case (state)
        DIR_IDLE: begin
          if (arriba && abajo) state_n = sube_cerca ? DIR_SUBE : DIR_BAJA;
          else if (arriba)     state_n = DIR_SUBE;
          else if (abajo)      state_n = DIR_BAJA;
        end
        DIR_SUBE: begin
          if (!arriba) state_n = abajo ? DIR_BAJA : DIR_IDLE;
        end
        DIR_BAJA: begin
          if (!abajo) state_n = arriba ? DIR_SUBE : DIR_IDLE;
        end
        default: state_n = DIR_IDLE;
      endcase
    end
  end

  always_comb begin
    tgt_found = 1'b0;
    tgt       = '0;
    case (state)
      DIR_SUBE: begin
        if (a_found)      begin tgt_found = 1'b1; tgt = a_idx; end
        else if (b_found) begin tgt_found = 1'b1; tgt = b_idx; end
      end
      DIR_BAJA: begin
        if (c_found)      begin tgt_found = 1'b1; tgt = c_idx; end
        else if (d_found) begin tgt_found = 1'b1; tgt = d_idx; end
      end
      default: begin
        if (|(pend & sel_p))          begin tgt_found = 1'b1; tgt = piso_actual; end
        else if (a_found && c_found)  begin tgt_found = 1'b1; tgt = sube_cerca ? a_idx : c_idx; end
        else if (a_found)             begin tgt_found = 1'b1; tgt = a_idx; end
        else if (c_found)             begin tgt_found = 1'b1; tgt = c_idx; end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIR_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cab            <= '0;
      up             <= '0;
      dn             <= '0;
      objetivo       <= '0;
      objetivo_valid <= 1'b0;
      err_req        <= 1'b0;
    end else begin
      if (borrar) begin
        cab <= '0;
        up  <= '0;
        dn  <= '0;
      end else begin
        cab <= (cab | ins_cab) & ~clr_cab;
        up  <= (up  | ins_up)  & ~clr_up;
        dn  <= (dn  | ins_dn)  & ~clr_dn;
      end
      if (!borrar && p_ok && tgt_found) objetivo <= tgt;
      objetivo_valid <= !borrar && (|pend);
      err_req        <= req.req_valid && req_ilegal;
    end
  end

  assign direccion = state;
  assign pend_cab  = cab;
  assign pend_up   = up;
  assign pend_dn   = dn;

endmodule

// File: tb/tb_planificador_solicitudes.sv
// Bench for planificador_solicitudes: directed scenarios plus random traffic
// on a 4-floor instance against a floor-level reference model; 8-floor instance for the nearest rule.
module tb_planificador_solicitudes;

  logic clk;
  logic rst;

  planificador_solicitudes_if #(.N_PISOS(4)) if4 ();
  planificador_solicitudes_if #(.N_PISOS(8)) if8 ();

  logic       b4, door4, val4, err4;
  logic [1:0] p4, acc4, obj4, dir4;
  logic [3:0] pc4, pu4, pd4;

  logic       b8, door8, val8, err8;
  logic [2:0] p8, obj8;
  logic [1:0] acc8, dir8;
  logic [7:0] pc8, pu8, pd8;

  planificador_solicitudes #(.N_PISOS(4)) dut4 (
    .clk(clk), .rst(rst), .req(if4), .borrar(b4), .piso_actual(p4), .accion(acc4),
    .puertas(door4), .objetivo(obj4), .objetivo_valid(val4), .direccion(dir4),
    .pend_cab(pc4), .pend_up(pu4), .pend_dn(pd4), .err_req(err4));

  planificador_solicitudes #(.N_PISOS(8)) dut8 (
    .clk(clk), .rst(rst), .req(if8), .borrar(b8), .piso_actual(p8), .accion(acc8),
    .puertas(door8), .objetivo(obj8), .objetivo_valid(val8), .direccion(dir8),
    .pend_cab(pc8), .pend_up(pu8), .pend_dn(pd8), .err_req(err8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esperado);
    n_checks++;
    if (obs !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, esperado, $time);
    end
  endtask

  // Reference model of the 4-floor instance (floor 0..3).
  logic [3:0] m_cab, m_up, m_dn;
  int         m_dir, m_obj;
  bit         m_val, m_err;

  task automatic model_reset();
    m_cab = '0; m_up = '0; m_dn = '0;
    m_dir = 0;  m_obj = 0; m_val = 0; m_err = 0;
  endtask

  function automatic int nearest(input logic [3:0] v, input int p);
    for (int d = 1; d < 4; d++) begin
      if (p + d < 4 && v[p+d] == 1'b1) return p + d;
      if (p - d >= 0 && v[p-d] == 1'b1) return p - d;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [3:0] pend, nc, nu, nd;
    int  p, piso, tipo, ndir, tgt, n;
    bit  arriba, abajo, ok, bad, tf;
    pend = m_cab | m_up | m_dn;
    p    = int'(p4);
    piso = int'(if4.req_piso);
    tipo = int'(if4.req_tipo);
    ok   = (p < 4);
    arriba = 0; abajo = 0;
    for (int f = 0; f < 4; f++) begin
      if (pend[f] && f > p) arriba = 1;
      if (pend[f] && f < p) abajo = 1;
    end
    ndir = m_dir;
    if (acc4 == 2'd0 && ok) begin
      if (m_dir == 0) begin
        if (arriba && abajo) ndir = (nearest(pend, p) > p) ? 1 : 2;
        else if (arriba)     ndir = 1;
        else if (abajo)      ndir = 2;
      end else if (m_dir == 1) ndir = arriba ? 1 : (abajo ? 2 : 0);
      else                     ndir = abajo ? 2 : (arriba ? 1 : 0);
    end
    tf = 0; tgt = 0;
    if (m_dir == 1) begin
      for (int f = 3; f > p; f--) if (m_cab[f] || m_up[f]) begin tf = 1; tgt = f; end
      if (!tf) for (int f = p + 1; f < 4; f++) if (m_dn[f]) begin tf = 1; tgt = f; end
    end else if (m_dir == 2) begin
      for (int f = 0; f < p; f++) if (m_cab[f] || m_dn[f]) begin tf = 1; tgt = f; end
      if (!tf) for (int f = p - 1; f >= 0; f--) if (m_up[f]) begin tf = 1; tgt = f; end
    end else begin
      if (pend[p]) begin tf = 1; tgt = p; end
      else begin
        n = nearest(pend, p);
        if (n >= 0) begin tf = 1; tgt = n; end
      end
    end
    bad = (tipo == 3) || (tipo == 1 && piso == 3) || (tipo == 2 && piso == 0);
    nc = m_cab; nu = m_up; nd = m_dn;
    if (if4.req_valid && !bad) begin
      if (tipo == 0) nc[piso] = 1'b1;
      if (tipo == 1) nu[piso] = 1'b1;
      if (tipo == 2) nd[piso] = 1'b1;
    end
    if (door4 && ok) begin
      nc[p] = 1'b0;
      if (m_dir != 2 || !abajo)  nu[p] = 1'b0;
      if (m_dir != 1 || !arriba) nd[p] = 1'b0;
    end
    m_err = if4.req_valid && bad;
    if (b4) begin
      m_cab = '0; m_up = '0; m_dn = '0; m_dir = 0; m_val = 0;
    end else begin
      m_cab = nc; m_up = nu; m_dn = nd;
      if (ok) begin
        m_dir = ndir;
        if (tf) m_obj = tgt;
      end
      m_val = (pend != 4'b0);
    end
  endtask

  task automatic compare_all();
    comprobar("pend_cab", 32'(pc4), 32'(m_cab));
    comprobar("pend_up",  32'(pu4), 32'(m_up));
    comprobar("pend_dn",  32'(pd4), 32'(m_dn));
    comprobar("direccion", 32'(dir4), 32'(m_dir));
    comprobar("objetivo", 32'(obj4), 32'(m_obj));
    comprobar("objetivo_valid", 32'(val4), 32'(m_val));
    comprobar("err_req", 32'(err4), 32'(m_err));
  endtask

  task automatic ciclo();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic pedir(input int tipo, input int piso);
    if4.req_valid = 1'b1;
    if4.req_tipo  = 2'(tipo);
    if4.req_piso  = 2'(piso);
  endtask

  task automatic pedir8(input int tipo, input int piso);
    if8.req_valid = 1'b1;
    if8.req_tipo  = 2'(tipo);
    if8.req_piso  = 3'(piso);
  endtask

  initial begin
    rst = 1'b1;
    if4.req_valid = 0; if4.req_tipo = 0; if4.req_piso = 0;
    if8.req_valid = 0; if8.req_tipo = 0; if8.req_piso = 0;
    b4 = 0; door4 = 0; p4 = 0; acc4 = 0;
    b8 = 0; door8 = 0; p8 = 0; acc8 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Sweep: cab 3, up 1, dn 2 from floor 0
    pedir(0, 3); ciclo();
    pedir(1, 1); ciclo();
    pedir(2, 2); ciclo();
    if4.req_valid = 0; ciclo();
    comprobar("t2_dir_sube", 32'(dir4), 32'd1);
    comprobar("t2_obj_1", 32'(obj4), 32'd1);
    p4 = 1; door4 = 1; ciclo();
    door4 = 0; ciclo();
    comprobar("t2_up1_clear", 32'(pu4), 32'd0);
    comprobar("t2_obj_3", 32'(obj4), 32'd3);
    p4 = 3; ciclo(); ciclo();
    comprobar("t2_dir_baja", 32'(dir4), 32'd2);
    comprobar("t2_obj_2", 32'(obj4), 32'd2);

    // Duplicates and illegal requests
    b4 = 1; ciclo(); b4 = 0;
    acc4 = 1; p4 = 0;
    pedir(0, 2); ciclo(); ciclo();
    if4.req_valid = 0; ciclo();
    comprobar("t3_dup_cab", 32'(pc4), 32'b0100);
    pedir(1, 3); ciclo();
    comprobar("t3_err_up_top", 32'(err4), 32'd1);
    comprobar("t3_up_unchanged", 32'(pu4), 32'd0);
    if4.req_valid = 0; ciclo();
    comprobar("t3_err_pulse_end", 32'(err4), 32'd0);
    pedir(3, 1); ciclo();
    comprobar("t3_err_tipo3", 32'(err4), 32'd1);
    pedir(2, 0); ciclo();
    comprobar("t3_err_dn_bottom", 32'(err4), 32'd1);
    if4.req_valid = 0;

    // Insert and service-clear of the same bit in one cycle
    b4 = 1; ciclo(); b4 = 0;
    p4 = 2; door4 = 1; pedir(0, 2); ciclo();
    if4.req_valid = 0; door4 = 0;
    comprobar("t4_clear_wins", 32'(pc4[2]), 32'd0);

    // Direction does not flip while moving
    b4 = 1; ciclo(); b4 = 0;
    p4 = 1; acc4 = 0; pedir(0, 3); ciclo();
    if4.req_valid = 0; ciclo();
    comprobar("t5_dir_sube", 32'(dir4), 32'd1);
    acc4 = 1; p4 = 3; door4 = 1; pedir(0, 0); ciclo();
    if4.req_valid = 0; door4 = 0;
    repeat (3) begin
      ciclo();
      comprobar("t5_hold_sube", 32'(dir4), 32'd1);
    end
    acc4 = 0; ciclo();
    comprobar("t5_flip_baja", 32'(dir4), 32'd2);

    // 8 floors: nearest-side rule from floor 3
    p8 = 3; acc8 = 1;
    pedir8(0, 7); ciclo();
    pedir8(0, 0); ciclo();
    if8.req_valid = 0; acc8 = 0; ciclo(); ciclo();
    comprobar("t6_dir_baja", 32'(dir8), 32'd2);
    comprobar("t6_obj_0", 32'(obj8), 32'd0);
    comprobar("t6_valid", 32'(val8), 32'd1);
    b8 = 1; ciclo(); b8 = 0;
    comprobar("t6_borrar_vec", 32'(pc8 | pu8 | pd8), 32'd0);
    comprobar("t6_borrar_dir", 32'(dir8), 32'd0);
    comprobar("t6_borrar_valid", 32'(val8), 32'd0);

    // Random traffic
    repeat (1500) begin
      if4.req_valid = 1'($urandom_range(0, 1));
      if4.req_tipo  = 2'($urandom_range(0, 3));
      if4.req_piso  = 2'($urandom_range(0, 3));
      b4    = ($urandom_range(0, 31) == 0);
      p4    = 2'($urandom_range(0, 3));
      acc4  = 2'($urandom_range(0, 2));
      door4 = ($urandom_range(0, 3) == 0);
      ciclo();
    end

    // Asynchronous reset in the middle of a cycle
    pedir(0, 1); b4 = 0; acc4 = 1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    comprobar("t1_dir8", 32'(dir8), 32'd0);
    comprobar("t1_pend8", 32'(pc8 | pu8 | pd8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if4.req_valid = 0; acc4 = 0;
    repeat (100) begin
      if4.req_valid = 1'($urandom_range(0, 1));
      if4.req_tipo  = 2'($urandom_range(0, 3));
      if4.req_piso  = 2'($urandom_range(0, 3));
      b4    = ($urandom_range(0, 63) == 0);
      p4    = 2'($urandom_range(0, 3));
      acc4  = 2'($urandom_range(0, 2));
      door4 = ($urandom_range(0, 3) == 0);
      ciclo();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
